// File: rtl/unsigned_divider_if.sv
// Operand/result bundle for the iterative unsigned divider.
// The master drives start and operands; the slave returns busy/done and the results.
interface unsigned_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, in1, in2,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, in1, in2,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/unsigned_divider.sv
// Restoring unsigned divider, one quotient bit per clock; results load WIDTH cycles after start (same edge for /0).
// No backpressure: start is ignored while busy, done is a one-cycle pulse.
module unsigned_divider #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic rst,
  unsigned_divider_if.slave bus
);

  localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH:0]   pr;
  logic [WIDTH+1:0] pr_shift;
  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   pr_nxt;
  logic [WIDTH-1:0] dvd_nxt;
  logic             ge;
  logic             accept;
  logic             zero_div;
  logic             last;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;
  logic             z_r;

  assign accept   = bus.start && (state != RUN);
  assign zero_div = (bus.in2 == '0);
  assign last     = (cnt == CW'(WIDTH - 1));

  // One extra bit above the partial remainder keeps the trial sign clean even
  // when a set dividend MSB meets a divisor above half range.
  assign pr_shift = {pr, dvd[WIDTH-1]};
  assign trial    = pr_shift - {2'b00, divisor};
  assign ge       = ~trial[WIDTH+1];
  assign pr_nxt   = ge ? trial[WIDTH:0] : pr_shift[WIDTH:0];
  assign dvd_nxt  = {dvd[WIDTH-2:0], ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_nxt = zero_div ? DONE : RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      divisor <= '0;
      dvd     <= '0;
      pr      <= '0;
      q_r     <= '0;
      r_r     <= '0;
      z_r     <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      divisor <= bus.in2;
      dvd     <= bus.in1;
      pr      <= '0;
      if (zero_div) begin
        q_r <= '1;
        r_r <= bus.in1;
        z_r <= 1'b1;
      end
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      dvd <= dvd_nxt;
      pr  <= pr_nxt;
      if (last) begin
        q_r <= dvd_nxt;
        r_r <= pr_nxt[WIDTH-1:0];
        z_r <= 1'b0;
      end
    end
  end

  assign bus.busy        = (state == RUN);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = q_r;
  assign bus.remainder   = r_r;
  assign bus.div_by_zero = z_r;

endmodule

// File: tb/tb_unsigned_divider.sv
// Directed-vector and corner-sequence bench for unsigned_divider (WIDTH=32).
// Results are compared against hand-computed values and the q*d+r identity.
module tb_unsigned_divider;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  unsigned_divider_if #(.WIDTH(W)) bus ();

  unsigned_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.in1   = a;
    bus.in2   = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.in1   = $urandom;
    bus.in2   = $urandom;
  endtask

  // Counts negedges until done; optionally pulses a 7/7 start at negedge 'inj'.
  task automatic wait_done(input int inj, output int lat, output int bcnt);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    bcnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (lat == inj) begin
        bus.start = 1'b1;
        bus.in1   = 7;
        bus.in2   = 7;
      end else if (lat == inj + 1) begin
        bus.start = 1'b0;
      end
      if (bus.busy) bcnt++;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) lat = -1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int bcnt;
    int nd;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic [63:0]  prod;

    tests = 0;
    fails = 0;

    vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    vecs[2]  = '{32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0};
    vecs[3]  = '{32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
    vecs[4]  = '{32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
    vecs[5]  = '{32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
    vecs[6]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
    vecs[7]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0};
    vecs[8]  = '{32'h12345678,   32'h00001000,   32'h00012345,   32'h00000678,   1'b0};
    vecs[9]  = '{32'hFFFFFFFF,   32'h80000001,   32'd1,          32'h7FFFFFFE,   1'b0};
    vecs[10] = '{32'hDEADBEEF,   32'h00000010,   32'h0DEADBEE,   32'h0000000F,   1'b0};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.in1   = '0;
    bus.in2   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_quotient", bus.quotient, 0);
    chk("rst_remainder", bus.remainder, 0);
    chk("rst_dbz", bus.div_by_zero, 0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      launch(vecs[i].a, vecs[i].b);
      wait_done(-1, lat, bcnt);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].z ? 1 : W + 1);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].z ? 0 : W);
      chk($sformatf("vec%0d_quotient", i), bus.quotient, vecs[i].q);
      chk($sformatf("vec%0d_remainder", i), bus.remainder, vecs[i].r);
      chk($sformatf("vec%0d_dbz", i), bus.div_by_zero, vecs[i].z);
      @(negedge clk);
      chk($sformatf("vec%0d_done_width", i), bus.done, 0);
    end

    // Start while busy is ignored, then a back-to-back start in the done cycle.
    launch(32'd1000, 32'd10);
    wait_done(5, lat, bcnt);
    chk("ignore_latency", lat, W + 1);
    chk("ignore_quotient", bus.quotient, 100);
    chk("ignore_remainder", bus.remainder, 0);
    bus.start = 1'b1;
    bus.in1   = 7;
    bus.in2   = 7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.in1   = $urandom;
    bus.in2   = $urandom;
    @(negedge clk);
    chk("b2b_done_single", bus.done, 0);
    chk("b2b_busy", bus.busy, 1);
    chk("b2b_hold_quotient", bus.quotient, 100);
    wait_done(-1, lat, bcnt);
    chk("b2b_latency", lat, W);
    chk("b2b_quotient", bus.quotient, 1);
    chk("b2b_remainder", bus.remainder, 0);

    // Reset mid-division aborts without a done pulse.
    launch(32'd1000, 32'd10);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_quotient", bus.quotient, 0);
    chk("abort_remainder", bus.remainder, 0);
    chk("abort_dbz", bus.div_by_zero, 0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    chk("abort_no_done", nd, 0);
    launch(32'd50, 32'd8);
    wait_done(-1, lat, bcnt);
    chk("post_abort_latency", lat, W + 1);
    chk("post_abort_quotient", bus.quotient, 6);
    chk("post_abort_remainder", bus.remainder, 2);

    for (int n = 0; n < 1200; n++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = $urandom | 32'h80000000;
        3:       begin a = W'($urandom_range(0, 255)); b = $urandom; end
        default: b = $urandom;
      endcase
      if (b == '0) begin
        eq = '1;
        er = a;
      end else begin
        eq = a / b;
        er = a % b;
      end
      launch(a, b);
      wait_done(-1, lat, bcnt);
      chk($sformatf("rand%0d_quotient %0h/%0h", n, a, b), bus.quotient, eq);
      chk($sformatf("rand%0d_remainder %0h/%0h", n, a, b), bus.remainder, er);
      chk($sformatf("rand%0d_dbz", n), bus.div_by_zero, (b == '0));
      if (b != '0) begin
        prod = 64'(bus.quotient) * 64'(b) + 64'(bus.remainder);
        chk($sformatf("rand%0d_identity", n), prod, 64'(a));
        chk($sformatf("rand%0d_rem_lt_div", n), (bus.remainder < b), 1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
